// File: rtl/rat_path_logger_if.sv
// Bus between the maze-solver/consumer side and the rat path logger.
// The master side drives solver status and drain backpressure; the logger (slave) returns the drained entries and status.
interface rat_path_logger_if #(
   parameter int unsigned DEPTH = 64
) ();
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          Start;
   logic [3:0]    X;
   logic [3:0]    Y;
   logic [1:0]    Move;
   logic          Done;
   logic          Fail;
   logic [9:0]    OutData;
   logic          OutValid;
   logic          OutReady;
   logic          OutLast;
   logic [CW-1:0] Count;
   logic          Overflow;
   logic          Busy;
   logic          Aborted;

   modport master (
      output Start, X, Y, Move, Done, Fail, OutReady,
      input  OutData, OutValid, OutLast, Count, Overflow, Busy, Aborted
   );

   modport slave (
      input  Start, X, Y, Move, Done, Fail, OutReady,
      output OutData, OutValid, OutLast, Count, Overflow, Busy, Aborted
   );
endinterface

// File: rtl/rat_path_logger.sv
// Logs the rat's distinct positions during a solver run into a small buffer,
// then drains them in capture order over a valid/ready stream.
module rat_path_logger #(
   parameter int unsigned DEPTH = 64
) (
   input  logic              CLK,
   input  logic              RST,
   rat_path_logger_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_CAPTURE,
      S_DRAIN,
      S_HALT
   } state_t;

   state_t        state_q;
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [7:0]    last_q;
   logic          overflow_q;
   logic          aborted_q;
   logic          busy_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic [EW-1:0] out_data_q;

   logic [7:0]    pos_c;
   logic [EW-1:0] entry_c;
   logic          moved_c;
   logic          full_c;
   logic          wr_en_c;
   logic [CW-1:0] count_d;
   logic [AW-1:0] rd_ptr_d;

   // Capture decode: a write needs a new position, room, and no restart/abort this cycle.
   always_comb begin
      pos_c    = {bus.X, bus.Y};
      entry_c  = {bus.Move, pos_c};
      moved_c  = (pos_c != last_q);
      full_c   = (count_q == CW'(DEPTH));
      wr_en_c  = (state_q == S_CAPTURE) && !RST && !bus.Start && !bus.Fail &&
                 moved_c && !full_c;
      count_d  = count_q + CW'(wr_en_c);
      rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge CLK) begin
      if (wr_en_c) begin
         mem_q[wr_ptr_q] <= entry_c;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         last_q      <= '0;
         overflow_q  <= 1'b0;
         aborted_q   <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (bus.Start) begin
         // Start from any state clears the log and re-arms, cutting off any drain.
         state_q     <= S_ARM;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         aborted_q   <= 1'b0;
         busy_q      <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            S_ARM: begin
               last_q  <= pos_c;
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (bus.Fail) begin
                  aborted_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_HALT;
               end else begin
                  if (moved_c) begin
                     last_q <= pos_c;
                     if (full_c) begin
                        overflow_q <= 1'b1;
                     end
                  end
                  if (wr_en_c) begin
                     wr_ptr_q <= wr_ptr_q + AW'(1);
                     count_q  <= count_d;
                  end
                  if (bus.Done) begin
                     if (count_d == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_HALT;
                     end else begin
                        // A lone entry written this cycle is not in memory yet; forward it.
                        state_q     <= S_DRAIN;
                        out_valid_q <= 1'b1;
                        out_data_q  <= (count_q == '0) ? entry_c : mem_q[rd_ptr_q];
                        out_last_q  <= (count_d == CW'(1));
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (bus.OutReady) begin
                  if (out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     state_q     <= S_HALT;
                  end else begin
                     rd_ptr_q   <= rd_ptr_d;
                     out_data_q <= mem_q[rd_ptr_d];
                     out_last_q <= (CW'(rd_ptr_d) == (count_q - CW'(1)));
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.OutData  = out_data_q;
   assign bus.OutValid = out_valid_q;
   assign bus.OutLast  = out_last_q;
   assign bus.Count    = count_q;
   assign bus.Overflow = overflow_q;
   assign bus.Busy     = busy_q;
   assign bus.Aborted  = aborted_q;
endmodule

// File: tb/tb_rat_path_logger.sv
// Self-checking bench for rat_path_logger: table-driven capture phases with a
// scoreboard of expected log entries, checked against the drained stream.
module tb_rat_path_logger;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [3:0] x;
      logic [3:0] y;
      logic [1:0] mv;
      logic       done;
      logic       fail;
      int         ecount;
      logic       ebusy;
      logic       evalid;
      logic       eovf;
   } row_t;

   logic CLK = 1'b0;
   logic RST;

   rat_path_logger_if #(.DEPTH(DEPTH)) bus ();
   rat_path_logger #(.DEPTH(DEPTH)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   int         n_checks = 0;
   int         n_fail   = 0;
   row_t       tbl[$];
   logic [9:0] exp_q[$];
   int         m_count;
   logic [7:0] m_last;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic void add(input int x, input int y, input int mv, input int done,
                               input int fail, input int ec, input int eb, input int ev,
                               input int eo);
      row_t r;
      r.x = 4'(x); r.y = 4'(y); r.mv = 2'(mv);
      r.done = 1'(done); r.fail = 1'(fail);
      r.ecount = ec; r.ebusy = 1'(eb); r.evalid = 1'(ev); r.eovf = 1'(eo);
      tbl.push_back(r);
   endfunction

   function automatic void build_path();
      tbl.delete();
      add(0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 0, 1, 0, 0, 1, 1, 0, 0);
      add(1, 1, 2, 0, 0, 2, 1, 0, 0);
      add(1, 1, 2, 0, 0, 2, 1, 0, 0);
      add(2, 1, 1, 0, 0, 3, 1, 0, 0);
      add(2, 1, 1, 1, 0, 3, 1, 1, 0);
   endfunction

   task automatic do_start(input string name);
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      m_count = 0;
      exp_q.delete();
      check({name, ".start_busy"}, int'(bus.Busy), 1);
      check({name, ".start_count"}, int'(bus.Count), 0);
      check({name, ".start_ovf"}, int'(bus.Overflow), 0);
      check({name, ".start_abort"}, int'(bus.Aborted), 0);
   endtask

   // Row 0 is presented during ARM and only seeds the model's last position.
   task automatic run_table(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         bus.X = tbl[i].x; bus.Y = tbl[i].y; bus.Move = tbl[i].mv;
         bus.Done = tbl[i].done; bus.Fail = tbl[i].fail;
         if (i == 0) begin
            m_last = {tbl[i].x, tbl[i].y};
         end else if (!tbl[i].fail && ({tbl[i].x, tbl[i].y} != m_last)) begin
            m_last = {tbl[i].x, tbl[i].y};
            if (m_count < int'(DEPTH)) begin
               exp_q.push_back({tbl[i].mv, tbl[i].x, tbl[i].y});
               m_count++;
            end
         end
         tick();
         check($sformatf("%s[%0d].count", name, i), int'(bus.Count), tbl[i].ecount);
         check($sformatf("%s[%0d].busy", name, i), int'(bus.Busy), int'(tbl[i].ebusy));
         check($sformatf("%s[%0d].valid", name, i), int'(bus.OutValid), int'(tbl[i].evalid));
         check($sformatf("%s[%0d].ovf", name, i), int'(bus.Overflow), int'(tbl[i].eovf));
      end
      bus.Done = 1'b0;
      bus.Fail = 1'b0;
   endtask

   task automatic drain(input string name, input int stall_idx, input int stall_n);
      int idx = 0;
      int stalls = 0;
      int cyc = 0;
      bit fin = 1'b0;
      logic [9:0] e;
      while (!fin && cyc < 50) begin
         cyc++;
         check($sformatf("%s.valid%0d", name, cyc), int'(bus.OutValid), 1);
         if (exp_q.size() == 0) begin
            fail_now({name, ".underflow"});
            break;
         end
         if (idx == stall_idx && stalls < stall_n) begin
            bus.OutReady = 1'b0;
            stalls++;
            check($sformatf("%s.held%0d", name, cyc), int'(bus.OutData), int'(exp_q[0]));
            check($sformatf("%s.held_last%0d", name, cyc), int'(bus.OutLast),
                  int'(exp_q.size() == 1));
         end else begin
            bus.OutReady = 1'b1;
            e = exp_q.pop_front();
            check($sformatf("%s.data%0d", name, idx), int'(bus.OutData), int'(e));
            check($sformatf("%s.last%0d", name, idx), int'(bus.OutLast),
                  int'(exp_q.size() == 0));
            if (exp_q.size() == 0) fin = 1'b1;
            idx++;
         end
         tick();
      end
      bus.OutReady = 1'b0;
      if (!fin) fail_now({name, ".timeout"});
      check({name, ".end_valid"}, int'(bus.OutValid), 0);
      check({name, ".end_busy"}, int'(bus.Busy), 0);
   endtask

   task automatic quiet(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check($sformatf("%s.valid_low%0d", name, i), int'(bus.OutValid), 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.Start = 1'b0; bus.X = '0; bus.Y = '0; bus.Move = '0;
      bus.Done = 1'b0; bus.Fail = 1'b0; bus.OutReady = 1'b0;
      m_count = 0; m_last = '0;
      RST = 1'b1;
      tick();
      tick();
      check("rst.valid", int'(bus.OutValid), 0);
      check("rst.last", int'(bus.OutLast), 0);
      check("rst.data", int'(bus.OutData), 0);
      check("rst.count", int'(bus.Count), 0);
      check("rst.busy", int'(bus.Busy), 0);
      check("rst.ovf", int'(bus.Overflow), 0);
      check("rst.abort", int'(bus.Aborted), 0);
      RST = 1'b0;
      tick();

      // Basic path capture and free-flowing drain.
      do_start("path");
      build_path();
      run_table("path");
      drain("path", -1, 0);
      check("path.halt_count", int'(bus.Count), 3);
      quiet("path", 2);

      // Backpressure on the second entry.
      do_start("bp");
      build_path();
      run_table("bp");
      drain("bp", 1, 3);

      // Overflow: six distinct positions into a four-entry log.
      do_start("ovf");
      tbl.delete();
      add(0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(1, 0, 1, 0, 0, 1, 1, 0, 0);
      add(2, 0, 2, 0, 0, 2, 1, 0, 0);
      add(3, 0, 3, 0, 0, 3, 1, 0, 0);
      add(4, 0, 0, 0, 0, 4, 1, 0, 0);
      add(5, 0, 1, 0, 0, 4, 1, 0, 1);
      add(6, 0, 2, 0, 0, 4, 1, 0, 1);
      add(6, 0, 2, 1, 0, 4, 1, 1, 1);
      run_table("ovf");
      drain("ovf", 2, 1);
      check("ovf.sticky", int'(bus.Overflow), 1);

      // Fail and Done together: abort wins, nothing drained.
      do_start("fail");
      tbl.delete();
      add(0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 1, 1, 0, 0, 1, 1, 0, 0);
      add(0, 2, 1, 0, 0, 2, 1, 0, 0);
      add(0, 3, 1, 1, 1, 2, 0, 0, 0);
      run_table("fail");
      check("fail.aborted", int'(bus.Aborted), 1);
      quiet("fail", 3);
      check("fail.count_hold", int'(bus.Count), 2);

      // Reset during the second handshake, then a clean run.
      do_start("rstmid");
      build_path();
      run_table("rstmid");
      bus.OutReady = 1'b1;
      check("rstmid.first", int'(bus.OutData), 'h110);
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      bus.OutReady = 1'b0;
      check("rstmid.valid", int'(bus.OutValid), 0);
      check("rstmid.count", int'(bus.Count), 0);
      check("rstmid.busy", int'(bus.Busy), 0);
      check("rstmid.data", int'(bus.OutData), 0);
      quiet("rstmid", 2);
      do_start("rerun");
      build_path();
      run_table("rerun");
      drain("rerun", -1, 0);

      // Start mid-drain restarts cleanly.
      do_start("restart");
      build_path();
      run_table("restart");
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      m_count = 0;
      exp_q.delete();
      check("restart.valid", int'(bus.OutValid), 0);
      check("restart.count", int'(bus.Count), 0);
      check("restart.busy", int'(bus.Busy), 1);
      build_path();
      run_table("restart2");
      drain("restart2", 0, 2);

      // Empty run: no movement, Done goes straight to HALT.
      do_start("empty");
      tbl.delete();
      add(3, 3, 0, 0, 0, 0, 1, 0, 0);
      add(3, 3, 1, 0, 0, 0, 1, 0, 0);
      add(3, 3, 1, 1, 0, 0, 0, 0, 0);
      run_table("empty");
      quiet("empty", 3);
      check("empty.count", int'(bus.Count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rat_path_logger.md
RAT_PATH_LOGGER -- requirements
Module: rat_path_logger

Interface
REQ-001 Parameter DEPTH, 64, number of path entries stored; power of two, 4..256.
REQ-002 Port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port RST  input  1  reset, synchronous, active-high.
REQ-004 Port Start  input  1  one-cycle pulse; clears the log and arms capture.
REQ-005 Port X, Y  input  4 each  rat's current coordinates from the maze-solver stage.
REQ-006 Port Move  input  2  rat's last move direction; stored alongside coordinates.
REQ-007 Port Done, Fail  input  1 each  solver completion and failure flags; level or pulse.
REQ-008 Port OutData  output  10  entry {Move, X, Y}, Move in bits 9:8.
REQ-009 Port OutValid  output  1  OutData holds a valid entry.
REQ-010 Port OutReady  input  1  consumer accepts the entry when OutValid and OutReady are both high.
REQ-011 Port OutLast  output  1  high with the final entry of the drain.
REQ-012 Port Count  output  log2(DEPTH)+1  number of entries stored.
REQ-013 Port Overflow  output  1  sticky; at least one step was dropped.
REQ-014 Port Busy  output  1  high in ARM, CAPTURE and DRAIN.
REQ-015 Port Aborted  output  1  sticky; the solver reported Fail during capture.

Function
REQ-016 The block SHALL implement five states: IDLE, ARM, CAPTURE, DRAIN, HALT.
REQ-017 IDLE: Start SHALL move the block to ARM, zero Count, write and read pointers, and clear Overflow and Aborted.
REQ-018 ARM: the block SHALL latch {X,Y} into the last-position register without writing an entry, then move to CAPTURE on the next cycle.
REQ-019 CAPTURE, on a cycle where {X,Y} differs from the last position:
  - write {Move,X,Y} at the write pointer;
  - increment the write pointer and Count;
  - update the last position.
REQ-020 CAPTURE, when {X,Y} equals the last position: the block SHALL not write an entry.
REQ-021 CAPTURE, buffer full (Count==DEPTH) and a new position arrives:
  - drop the entry;
  - set Overflow;
  - still update the last position.
REQ-022 CAPTURE, Done high:
  - a differing position on the same cycle SHALL be written first;
  - then move to DRAIN, or to HALT if Count (including that write) is 0.
REQ-023 CAPTURE, Fail high: set Aborted and move to HALT with no write; Fail SHALL take priority when Fail and Done are high together.
REQ-024 DRAIN, output behaviour:
  - OutData SHALL show the entry at the read pointer;
  - OutValid SHALL be high;
  - on each accepted handshake the read pointer SHALL advance by one.
REQ-025 DRAIN handshake rules:
  - OutData SHALL hold stable while OutValid is high and OutReady is low;
  - the first entry SHALL be valid in the first DRAIN cycle, and one entry SHALL be accepted per cycle at most;
  - OutLast SHALL be high exactly when read pointer == Count-1.
REQ-026 DRAIN: acceptance of the OutLast entry SHALL move the block to HALT; entries SHALL come out in capture order.
REQ-027 HALT: Count, Overflow and Aborted SHALL hold; Start SHALL re-enter ARM with the clearing actions of REQ-017.
REQ-028 Start during ARM, CAPTURE or DRAIN SHALL restart: clear as in REQ-017, go to ARM, and end any drain in progress with OutValid low on the next cycle.
REQ-029 Count SHALL saturate at DEPTH; the pointers SHALL wrap modulo DEPTH; OutValid SHALL be low in every state other than DRAIN.

Reset
REQ-030 While RST is high at a clock edge, the block SHALL enter IDLE and set to zero on that edge: OutValid, OutLast, OutData, Count, Overflow, Busy, Aborted, both pointers and the last-position register.
REQ-031 RST SHALL take priority over Start, Done and Fail; buffer contents need not be cleared.

Verification
REQ-032 Path capture: Start, then X,Y = (0,0),(1,0),(1,1),(1,1),(2,1) with Move = 0,1,2,2,1, then Done, OutReady=1 -> Count=3; OutData 0x110, 0x211, 0x121 on consecutive cycles; OutLast only on 0x121; state HALT.
REQ-033 Backpressure: same path, OutReady low for 3 cycles during the second entry -> 0x211 held stable with OutValid=1; no entry lost or duplicated.
REQ-034 Overflow: DEPTH=4, six distinct positions, then Done -> Count=4, Overflow=1, four oldest entries drained.
REQ-035 Fail: Start, two moves, then Fail and Done in the same cycle -> Aborted=1, HALT, OutValid never high, Count=2.
REQ-036 Reset mid-drain: RST during the second handshake -> next cycle IDLE, OutValid=0, Count=0; a new Start and path logs correctly.
REQ-037 Empty run: Start, position unchanged, then Done -> HALT directly, Count=0, OutValid never asserted.
